my_stack: RTL and testbench

- Hardware return-address stack for the CPU's program-counter block.
- On a CALL opcode it pushes the caller's return address (called_from + 1). On a RET opcode it pops.
- The current top entry is always presented combinationally on return_to, so the PC block can load it in the same cycle as RET.
- Fixed-depth LIFO, register-based, single clock domain.

---
 rtl/my_stack.sv | 101 ++++++++++
 tb/tb_my_stack.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/my_stack.sv
// Return-address stack: CALL pushes called_from+1, RET pops, and return_to shows the top combinationally.
// Define MYSTACK_ERR_FLAGS_EN to add the sticky overflow/underflow outputs.
module my_stack #(
    parameter int                      OPCODE_WIDTH = 4,
    parameter int                      PC_WIDTH     = 8,
    parameter int                      DEPTH        = 16,
    parameter logic [OPCODE_WIDTH-1:0] CALL_CODE    = 4'd5,
    parameter logic [OPCODE_WIDTH-1:0] RET_CODE     = 4'd6,
    parameter logic [OPCODE_WIDTH-1:0] RESET_CODE   = 4'd15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [OPCODE_WIDTH-1:0]    reset_code,
    input  logic [PC_WIDTH-1:0]        called_from,
    output logic [PC_WIDTH-1:0]        return_to,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       empty,
    output logic                       full
`ifdef MYSTACK_ERR_FLAGS_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [PC_WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]      sp_q, sp_d;
    logic [SPW-1:0]      sp_m1;
    logic                push_en;
    logic                is_flush, is_call, is_ret;

    assign is_flush = (reset_code == RESET_CODE);
    assign is_call  = (reset_code == CALL_CODE);
    assign is_ret   = (reset_code == RET_CODE);

    assign empty = (sp_q == '0);
    assign full  = (sp_q == SPW'(DEPTH));
    assign depth = sp_q;

    always_comb begin
        sp_d    = sp_q;
        push_en = 1'b0;
        if (is_flush) begin
            sp_d = '0;
        end else if (is_call) begin
            if (!full) begin
                sp_d    = sp_q + SPW'(1);
                push_en = 1'b1;
            end
        end else if (is_ret) begin
            if (!empty) sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) sp_q <= '0;
        else       sp_q <= sp_d;
    end

    // Storage is never cleared; sp alone defines which entries are valid.
    always_ff @(posedge clock) begin
        if (!reset && push_en) mem_q[sp_q[AW-1:0]] <= called_from + PC_WIDTH'(1);
    end

    assign sp_m1     = sp_q - SPW'(1);
    assign return_to = empty ? '0 : mem_q[sp_m1[AW-1:0]];

`ifdef MYSTACK_ERR_FLAGS_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (is_flush) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else if (is_call && full) begin
            ovf_d = 1'b1;
        end else if (is_ret && empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_my_stack.sv
// Bench for my_stack: directed scenarios then random traffic against a queue-based model.
module tb_my_stack;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] reset_code;
    logic [7:0] called_from;
    logic [7:0] return_to;
    logic [4:0] depth;
    logic       empty, full;
`ifdef MYSTACK_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif

    my_stack dut (
        .clock       (clock),
        .reset       (reset),
        .reset_code  (reset_code),
        .called_from (called_from),
        .return_to   (return_to),
        .depth       (depth),
        .empty       (empty),
        .full        (full)
`ifdef MYSTACK_ERR_FLAGS_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always #5 clock = ~clock;

    localparam logic [3:0] NOP = 4'd0, CALL = 4'd5, RET = 4'd6, FLUSH = 4'd15;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] stk[$];
    bit         m_ovf, m_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [7:0] ert;
        ert = (stk.size() != 0) ? stk[stk.size()-1] : 8'h00;
        chk("depth", 32'(depth), 32'(stk.size()));
        chk("empty", 32'(empty), 32'(stk.size() == 0));
        chk("full", 32'(full), 32'(stk.size() == 16));
        chk("return_to", 32'(return_to), 32'(ert));
`ifdef MYSTACK_ERR_FLAGS_EN
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
`endif
    endtask

    // One clock: check pre-edge state, apply op, update model after the edge.
    task automatic step(input bit rst, input logic [3:0] op, input logic [7:0] pc);
        @(negedge clock);
        check_state();
        reset       = rst;
        reset_code  = op;
        called_from = pc;
        @(posedge clock);
        #1;
        reset      = 1'b0;
        reset_code = NOP;
        if (rst || op == FLUSH) begin
            stk.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (op == CALL) begin
            if (stk.size() < 16) stk.push_back(pc + 8'd1);
            else                 m_ovf = 1'b1;
        end else if (op == RET) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else                m_udf = 1'b1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        reset_code  = NOP;
        called_from = 8'h00;
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset
        step(1'b1, NOP, 8'h00);
        @(negedge clock);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_rt", 32'(return_to), 0);

        // Single call/return
        step(1'b0, CALL, 8'h10);
        @(negedge clock);
        chk("single_rt", 32'(return_to), 32'h11);
        step(1'b0, RET, 8'h00);
        step(1'b0, NOP, 8'h00);

        // Nested calls
        step(1'b0, CALL, 8'h02);
        step(1'b0, CALL, 8'h20);
        step(1'b0, CALL, 8'h40);
        @(negedge clock);
        chk("nest_rt", 32'(return_to), 32'h41);
        step(1'b0, RET, 8'h00);
        step(1'b0, RET, 8'h00);
        @(negedge clock);
        chk("nest_last_rt", 32'(return_to), 32'h03);
        step(1'b0, RET, 8'h00);
        step(1'b0, NOP, 8'h00);

        // Overflow
        step(1'b1, NOP, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b0, CALL, 8'(i));
        @(negedge clock);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_rt", 32'(return_to), 32'd16);
        step(1'b0, CALL, 8'h80);
        @(negedge clock);
        chk("ovf_depth", 32'(depth), 32'd16);
        chk("ovf_rt_kept", 32'(return_to), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, RET, 8'h00);

        // Underflow and soft reset
        step(1'b1, NOP, 8'h00);
        step(1'b0, RET, 8'h00);
        @(negedge clock);
        chk("udf_depth", 32'(depth), 0);
        chk("udf_rt", 32'(return_to), 0);
        step(1'b0, CALL, 8'h31);
        step(1'b0, CALL, 8'h32);
        step(1'b0, CALL, 8'h33);
        step(1'b0, FLUSH, 8'h00);
        @(negedge clock);
        chk("flush_depth", 32'(depth), 0);
        chk("flush_empty", 32'(empty), 1);

        // Address wrap
        step(1'b0, CALL, 8'hFF);
        @(negedge clock);
        chk("wrap_rt", 32'(return_to), 0);
        chk("wrap_depth", 32'(depth), 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int         r;
            logic [3:0] op;
            r = int'($urandom_range(0, 99));
            if      (r < 45) op = CALL;
            else if (r < 85) op = RET;
            else if (r < 88) op = FLUSH;
            else             op = 4'($urandom_range(0, 15));
            step(r == 99, op, 8'($urandom));
        end
        @(negedge clock);
        check_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
